// File: rtl/vx_ahb_pkg.sv
// Shared AHB-Lite types for the Vortex memory path: transfer/size encodings,
// response constants and the SRAM subordinate state machine encoding.
package vx_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } sub_state_t;

  // Byte lanes touched by a transfer; illegal sizes fall into the word case and are rejected elsewhere.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous clear, enable and programmable rollover.
// wrap is high on the enabled cycle where count equals max; count then returns to 0.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = en && (count == max);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vx_ahb_sram_sub.sv
// AHB-Lite word SRAM subordinate: pipelined address/data phases, byte-lane writes, RAW forwarding,
// two-cycle ERROR. Define VX_AHB_SUB_WAIT_EN to insert WAIT_STATES wait cycles per legal data phase.
module vx_ahb_sram_sub #(
  parameter int          MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);
  import vx_ahb_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);

  if (WAIT_STATES < 1 || WAIT_STATES > 15 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_param_check
    $error("vx_ahb_sram_sub: illegal parameter set");
  end

  sub_state_t  state, state_next, legal_state, dispatch;
  logic        accept, legal, size_ok, align_ok, range_ok;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic [3:0]  mask;
  logic        dp_write;
  logic [AW-1:0] dp_idx;
  logic [3:0]  dp_mask;
  logic        wr_commit, fwd_hit, wait_done;
  logic [31:0] mem_q, rd_word;
  logic        unused_addr_bits;

  logic [31:0] mem [MEM_WORDS];

  // Address-phase decode
  assign accept   = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign offset   = HADDR - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign range_ok = (offset[31:AW+2] == '0);
  assign size_ok  = (HSIZE <= HSIZE_WORD);
  assign mask     = lane_mask(HSIZE, HADDR[1:0]);
  assign legal    = size_ok && align_ok && range_ok;
  assign unused_addr_bits = ^offset[1:0];

  always_comb begin
    align_ok = 1'b1;
    case (HSIZE)
      HSIZE_HALF: align_ok = !HADDR[0];
      HSIZE_WORD: align_ok = (HADDR[1:0] == 2'b00);
      default:    align_ok = 1'b1;
    endcase
  end

`ifdef VX_AHB_SUB_WAIT_EN
  logic [3:0] unused_wait_cnt;

  counter #(.WIDTH(4)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == ST_WAIT),
    .max   (4'(WAIT_STATES - 1)),
    .count (unused_wait_cnt),
    .wrap  (wait_done)
  );
  assign legal_state = ST_WAIT;
`else
  assign wait_done   = 1'b1;
  assign legal_state = ST_DATA;
`endif

  assign HREADY = (state != ST_ERR1) && (state != ST_WAIT);
  assign HRESP  = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    dispatch   = ST_IDLE;
    state_next = ST_IDLE;
    if (accept) dispatch = legal ? legal_state : ST_ERR1;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: state_next = dispatch;
      ST_WAIT:                   state_next = wait_done ? ST_DATA : ST_WAIT;
      ST_ERR1:                   state_next = ST_ERR2;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Write lands in the completing data-phase cycle; a read in the same cycle sees the merged word.
  assign wr_commit = dp_write && (state == ST_DATA);
  assign fwd_hit   = wr_commit && (dp_idx == idx);
  assign mem_q     = mem[idx];

  always_comb begin
    rd_word = mem_q;
    for (int b = 0; b < 4; b++) begin
      if (fwd_hit && dp_mask[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_mask  <= '0;
      HRDATA   <= '0;
    end else if (HREADY) begin
      dp_write <= accept && legal && HWRITE;
      if (accept) begin
        dp_idx  <= idx;
        dp_mask <= mask;
      end
      if (accept && legal && !HWRITE) HRDATA <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_mask[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vx_ahb_sram_sub.sv
// Directed bench for vx_ahb_sram_sub: table of AHB transfers run through a pipelined master,
// plus hand-written reset sequences.
module tb_vx_ahb_sram_sub;

  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          WS        = 2;
`ifdef VX_AHB_SUB_WAIT_EN
  localparam int WS_EXP = WS;
`else
  localparam int WS_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  always #5 clk = ~clk;

  vx_ahb_sram_sub #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } vec_t;

  vec_t  vq[$];
  int    n_pass = 0;
  int    n_total = 0;
  string cur_tag;
  int    cur_idx;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s[%0d] %s: got %h expected %h", cur_tag, cur_idx, what, act, exp);
    else
      n_pass++;
  endtask

  task automatic add(input logic sel, input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                     input logic [2:0] size, input logic [31:0] wdata, input logic err,
                     input logic chk, input logic [31:0] rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.addr = addr; v.wr = wr; v.size = size;
    v.wdata = wdata; v.err = err; v.chk = chk; v.rdata = rdata;
    vq.push_back(v);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    add(1'b1, 2'b10, a, 1'b1, 3'b010, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd32(input logic [31:0] a, input logic [31:0] exp);
    add(1'b1, 2'b10, a, 1'b0, 3'b010, 32'h0, 1'b0, 1'b1, exp);
  endtask

  function automatic int exp_low(input vec_t v);
    if (!(v.sel && v.trans[1])) return 0;
    if (v.err) return 1;
    return WS_EXP;
  endfunction

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'b010;
  endtask

  // Pipelined master: address of vq[ai] overlaps the data phase of vq[di]; both advance on HREADY.
  task automatic run_vectors(input string tag);
    int   ai, di, low, budget, n;
    logic rdy, resp, low_ok;
    logic [31:0] rd;
    n = vq.size(); ai = 0; di = -1; low = 0; budget = 0; low_ok = 1'b1;
    cur_tag = tag;
    while (1) begin
      if (ai < n) begin
        HSEL = vq[ai].sel; HTRANS = vq[ai].trans; HADDR = vq[ai].addr;
        HWRITE = vq[ai].wr; HSIZE = vq[ai].size;
      end else begin
        drive_idle();
      end
      HWDATA = (di >= 0) ? vq[di].wdata : 32'h0;
      @(negedge clk);
      rdy = HREADY; resp = HRESP; rd = HRDATA;
      if (di >= 0) begin
        cur_idx = di;
        if (!rdy) begin
          low++;
          if (resp !== vq[di].err) low_ok = 1'b0;
        end else begin
          check("hresp", {31'h0, resp}, {31'h0, vq[di].err});
          check("wait_cycles", 32'(low), 32'(exp_low(vq[di])));
          check("hresp_while_low", {31'h0, low_ok}, 32'h1);
          if (vq[di].chk) check("hrdata", rd, vq[di].rdata);
          low = 0; low_ok = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (ai < n) begin di = ai; ai++; end
        else break;
      end
      budget++;
      if (budget > 30 * n + 20) begin
        cur_idx = di;
        check("timeout", 32'h1, 32'h0);
        break;
      end
    end
    drive_idle();
    HWDATA = 32'h0;
    vq.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    HWDATA = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cur_tag = "reset"; cur_idx = 0;
    check("hready", {31'h0, HREADY}, 32'h1);
    check("hresp", {31'h0, HRESP}, 32'h0);
    check("hrdata", HRDATA, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) wr32(BASE + 32'h40 + 32'(4 * i), 32'h1000 + 32'(i));
    for (int i = 0; i < 16; i++) rd32(BASE + 32'h40 + 32'(4 * i), 32'h1000 + 32'(i));
    run_vectors("burst");

    wr32(32'h80, 32'hAABB_CCDD);
    add(1'b1, 2'b10, 32'h82, 1'b1, 3'b000, 32'h0011_0000, 1'b0, 1'b0, 32'h0);
    rd32(32'h80, 32'hAA11_CCDD);
    rd32(32'h80, 32'hAA11_CCDD);
    run_vectors("bytelane");

    wr32(32'h100, 32'h1234_5678);
    rd32(32'h100, 32'h1234_5678);
    run_vectors("forward");

    wr32(32'h000, 32'h0A0A_0A0A);
    add(1'b1, 2'b10, 32'h102, 1'b0, 3'b010, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    add(1'b1, 2'b10, 32'h100, 1'b0, 3'b011, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    add(1'b1, 2'b10, BASE + 32'(MEM_WORDS * 4), 1'b0, 3'b010, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    add(1'b1, 2'b10, 32'h102, 1'b1, 3'b010, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    add(1'b1, 2'b10, 32'h101, 1'b1, 3'b001, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    add(1'b1, 2'b10, BASE + 32'(MEM_WORDS * 4), 1'b1, 3'b010, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    rd32(32'h100, 32'h1234_5678);
    rd32(32'h000, 32'h0A0A_0A0A);
    run_vectors("errors");

    add(1'b1, 2'b01, 32'h100, 1'b1, 3'b010, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    add(1'b0, 2'b10, 32'h100, 1'b1, 3'b010, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    add(1'b1, 2'b11, 32'h100, 1'b0, 3'b010, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    wr32(32'h104, 32'h5566_7788);
    add(1'b1, 2'b10, 32'h106, 1'b1, 3'b001, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0);
    rd32(32'h104, 32'hCAFE_7788);
    add(1'b1, 2'b10, 32'h105, 1'b1, 3'b000, 32'h0000_3300, 1'b0, 1'b0, 32'h0);
    rd32(32'h104, 32'hCAFE_3388);
    wr32(32'h200, 32'h0);
    run_vectors("misc");

    // Write to 0x200 whose data phase collides with reset must be dropped.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h200; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge clk); #1;
    drive_idle();
    HWDATA = 32'hDEAD_BEEF;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    HWDATA = 32'h0;
    @(negedge clk);
    cur_tag = "midreset"; cur_idx = 0;
    check("hready", {31'h0, HREADY}, 32'h1);
    check("hrdata", HRDATA, 32'h0);
    @(posedge clk); #1;
    rd32(32'h200, 32'h0);
    rd32(32'h100, 32'h1234_5678);
    run_vectors("midreset_read");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
